battleship_tx_framer: RTL and testbench
=======================================

Name: battleship_tx_framer

Overview:
- Upstream feeder of the UART serial block.
- Accepts one game message (type, row, col) from the game FSM and frames it as a 4-byte packet: SYNC, {row,col}, type, checksum.
- Drives the serial block's parDataOut/load/transmitEnable handshake one byte at a time and waits on charSent between bytes.
- Runs on the system clock; the serial block's 16x clock is derived from the same clock.

Parameters:
GAP_CYCLES, 400, clk cycles transmitEnable is held low between bytes (must exceed one clk16x period of 325 clk)
TIMEOUT_CYCLES, 65536, clk cycles allowed in SEND without a charSent rise before abort
MAX_COORD, 9, largest legal row/col value (10x10 board)

Ports:
clk  input  1  system clock; all logic on posedge
reset  input  1  synchronous, active-high reset
msgValid  input  1  game FSM offers a message
msgReady  output  1  framer can accept; high only in IDLE
msgType  input  2  0=SHOT 1=HIT 2=MISS 3=SUNK
row  input  4  board row
col  input  4  board column
charSent  input  1  from serial block; high for a window after each character completes
parDataOut  output  8  byte to the serial block's transmit shift register
load  output  1  one-cycle load strobe to the serial block
transmitEnable  output  1  enables the serial block's transmit shift/count
busy  output  1  packet in progress
txDone  output  1  one-cycle pulse after the last byte's gap completes
txError  output  1  one-cycle pulse on coordinate reject or timeout

Behaviour:
- Reset, in any state:
  - next state is IDLE.
  - parDataOut=8'h00; load, transmitEnable, busy, txDone and txError are 0.
  - byte index and all counters clear.
  - msgReady=1 once in IDLE.
  - Reset mid-packet discards the message; transmitEnable drops on the next edge; no txDone is generated.
- Packet bytes are captured on accept:
  - b0=8'hA5
  - b1={row,col}
  - b2={6'b0,msgType}
  - b3=b0^b1^b2
- Accept: msgValid && msgReady at edge N.
  - row>MAX_COORD or col>MAX_COORD: reject. Stay in IDLE, txError=1 for cycle N+1, nothing is transmitted.
  - Otherwise go to SETUP and set busy=1.
- msgValid outside IDLE is ignored and nothing is captured.
- FSM states:
  - IDLE: msgReady=1.
  - SETUP, 1 cycle: parDataOut=b[idx]; load=0. This separates data setup from the load edge.
  - LOAD, 1 cycle: load=1; parDataOut is held.
  - SEND:
    - load=0, transmitEnable=1, timeout counter runs.
    - On a charSent rising edge (registered previous value vs current), go to GAP.
    - If the counter reaches TIMEOUT_CYCLES-1 first, go to IDLE with txError pulse; busy and transmitEnable go to 0.
  - GAP:
    - transmitEnable=0; gap counter counts to GAP_CYCLES-1.
    - Exit only when the count has expired AND charSent==0; otherwise hold.
    - On exit with idx<3: idx++ and go to SETUP.
    - On exit with idx==3: go to IDLE with txDone pulse and busy=0.
- parDataOut holds its value from SETUP through GAP of each byte.
- charSent edges seen outside SEND are ignored. The edge register updates every cycle, so a level that is already high on entry to SEND does not count as a rise.
- Latency: first load pulse at N+2; transmitEnable rises at N+3.
- Counters are sized to $clog2 of their parameter; no wrap occurs because each is cleared on state entry.

Decomposition:
- Package battleship_link_pkg holds:
  - SYNC_BYTE=8'hA5
  - MSG_SHOT/HIT/MISS/SUNK encodings
  - PKT_LEN=4
  - state enum {IDLE,SETUP,LOAD,SEND,GAP}
- One sub-module, char_sent_edge: registers charSent and outputs the rise pulse. It is reused later by the receive-side deframer.

Test Plan:
(Bench uses GAP_CYCLES=4 and TIMEOUT_CYCLES=50. The charSent model pulses high 3 cycles, 10 cycles after transmitEnable rises, and falls when transmitEnable falls.)
1. Normal packet, type=1 row=3 col=7:
   - parDataOut sequence A5, 37, 01, 93, each with one load pulse.
   - 4 transmitEnable windows.
   - txDone single pulse; msgReady back to 1.
2. Reject, row=10 col=2: txError pulse at N+1; load never asserts; msgReady stays 1.
3. Timeout, charSent held 0: txError 50 cycles after SEND entry; transmitEnable=0; busy=0; state IDLE.
4. Stuck charSent, held high past gap expiry after byte 1: framer stays in GAP and no next load until charSent falls. Then b2 proceeds.
5. Reset asserted during byte 2 SEND: next cycle transmitEnable=0, load=0, parDataOut=00, msgReady=1, and no txDone. A new message then sends from b0=A5.
6. msgValid pulsed while busy with row=1 col=1: ignored; the in-flight packet's bytes are unchanged.

Source files
------------

// File: rtl/battleship_link_pkg.sv
// Shared definitions for the battleship serial link: packet framing constants,
// message encodings and the framer state type.
package battleship_link_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    localparam logic [1:0] MSG_SHOT = 2'd0;
    localparam logic [1:0] MSG_HIT  = 2'd1;
    localparam logic [1:0] MSG_MISS = 2'd2;
    localparam logic [1:0] MSG_SUNK = 2'd3;

    localparam int PKT_LEN = 4;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        LOAD,
        SEND,
        GAP
    } link_state_e;

    function automatic logic [7:0] pkt_checksum(input logic [7:0] b0,
                                                input logic [7:0] b1,
                                                input logic [7:0] b2);
        return b0 ^ b1 ^ b2;
    endfunction

endpackage

// File: rtl/char_sent_edge.sv
// Rise detector for the serial block's charSent window; the previous-level
// register updates every cycle so a level already high never reads as a rise.
module char_sent_edge (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic rise
);

    logic prev;

    always_ff @(posedge clk) begin
        if (reset) prev <= 1'b0;
        else       prev <= level;
    end

    assign rise = level & ~prev;

endmodule

// File: rtl/battleship_tx_framer.sv
// Frames one game message into SYNC/{row,col}/type/checksum and hands it to the
// UART serial block a byte at a time over the load/transmitEnable/charSent handshake.
module battleship_tx_framer
    import battleship_link_pkg::*;
#(
    parameter int GAP_CYCLES     = 400,
    parameter int TIMEOUT_CYCLES = 65536,
    parameter int MAX_COORD      = 9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       msgValid,
    output logic       msgReady,
    input  logic [1:0] msgType,
    input  logic [3:0] row,
    input  logic [3:0] col,
    input  logic       charSent,
    output logic [7:0] parDataOut,
    output logic       load,
    output logic       transmitEnable,
    output logic       busy,
    output logic       txDone,
    output logic       txError
);

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]    COORD_MAX = 4'(MAX_COORD);
    localparam logic [1:0]    LAST_IDX  = 2'(PKT_LEN - 1);

    link_state_e           state;
    logic [1:0]            idx;
    // b0 is the constant sync byte, so only bytes 1..3 are stored.
    logic [PKT_LEN-1:1][7:0] tail;
    logic [GW-1:0]         gap_cnt;
    logic [TW-1:0]         tmo_cnt;
    logic                  char_rise;
    logic                  coord_ok;
    logic [7:0]            b1;
    logic [7:0]            b2;

    assign b1       = {row, col};
    assign b2       = {6'b0, msgType};
    assign coord_ok = (row <= COORD_MAX) && (col <= COORD_MAX);
    assign msgReady = (state == IDLE);

    char_sent_edge u_edge (
        .clk   (clk),
        .reset (reset),
        .level (charSent),
        .rise  (char_rise)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            idx            <= '0;
            tail           <= '0;
            gap_cnt        <= '0;
            tmo_cnt        <= '0;
            parDataOut     <= 8'h00;
            load           <= 1'b0;
            transmitEnable <= 1'b0;
            busy           <= 1'b0;
            txDone         <= 1'b0;
            txError        <= 1'b0;
        end else begin
            load    <= 1'b0;
            txDone  <= 1'b0;
            txError <= 1'b0;
            case (state)
                IDLE: begin
                    if (msgValid) begin
                        if (!coord_ok) begin
                            txError <= 1'b1;
                        end else begin
                            tail       <= {pkt_checksum(SYNC_BYTE, b1, b2), b2, b1};
                            idx        <= '0;
                            parDataOut <= SYNC_BYTE;
                            busy       <= 1'b1;
                            state      <= SETUP;
                        end
                    end
                end
                // Data is already stable here; the strobe comes one edge later.
                SETUP: begin
                    load  <= 1'b1;
                    state <= LOAD;
                end
                LOAD: begin
                    transmitEnable <= 1'b1;
                    tmo_cnt        <= '0;
                    state          <= SEND;
                end
                SEND: begin
                    if (char_rise) begin
                        transmitEnable <= 1'b0;
                        gap_cnt        <= '0;
                        state          <= GAP;
                    end else if (tmo_cnt == TMO_LAST) begin
                        transmitEnable <= 1'b0;
                        busy           <= 1'b0;
                        txError        <= 1'b1;
                        state          <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                // Counter saturates; a charSent still high holds us here.
                GAP: begin
                    if (gap_cnt != GAP_LAST) begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end else if (!charSent) begin
                        if (idx == LAST_IDX) begin
                            busy   <= 1'b0;
                            txDone <= 1'b1;
                            state  <= IDLE;
                        end else begin
                            idx        <= idx + 2'd1;
                            parDataOut <= tail[idx + 2'd1];
                            state      <= SETUP;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_battleship_tx_framer.sv
// Randomized bench for battleship_tx_framer: a packet-level model predicts the
// byte stream and handshake timing, and a monitor compares every cycle.
module tb_battleship_tx_framer;

    localparam int GAP = 4;
    localparam int TMO = 50;

    logic       clk;
    logic       reset;
    logic       msgValid;
    logic       msgReady;
    logic [1:0] msgType;
    logic [3:0] row;
    logic [3:0] col;
    logic       charSent;
    logic [7:0] parDataOut;
    logic       load;
    logic       transmitEnable;
    logic       busy;
    logic       txDone;
    logic       txError;

    battleship_tx_framer #(
        .GAP_CYCLES     (GAP),
        .TIMEOUT_CYCLES (TMO),
        .MAX_COORD      (9)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .msgValid       (msgValid),
        .msgReady       (msgReady),
        .msgType        (msgType),
        .row            (row),
        .col            (col),
        .charSent       (charSent),
        .parDataOut     (parDataOut),
        .load           (load),
        .transmitEnable (transmitEnable),
        .busy           (busy),
        .txDone         (txDone),
        .txError        (txError)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // model / monitor state
    logic [7:0] exp_q[$];
    logic [7:0] load_log[$];
    int         load_cyc_log[$];
    int         te_rises = 0;
    int         te_rise_cyc = 0;
    int         te_fall_cyc = 0;
    logic [7:0] last_loaded = 8'h00;
    bit         stuck_pkt = 0;

    // charSent generator controls
    bit no_sent = 0;
    int stuck_win = 0;
    int gen_win = 0;
    int stuck_fall_cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    function automatic logic [31:0] pkt_word(input logic [1:0] t, input logic [3:0] r,
                                             input logic [3:0] c);
        logic [7:0] p0, p1, p2;
        p0 = 8'hA5;
        p1 = {r, c};
        p2 = {6'd0, t};
        return {p0, p1, p2, p0 ^ p1 ^ p2};
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Serial-block stand-in: charSent high 3 cycles starting 10 cycles into
    // each transmitEnable window, dropping when transmitEnable drops.
    initial begin
        int  te_cnt;
        int  stuck_left;
        bit  prev_te_g;
        te_cnt = 0;
        stuck_left = 0;
        prev_te_g = 0;
        charSent = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (reset || txDone || txError) gen_win = 0;
            if (transmitEnable && !prev_te_g) begin
                gen_win++;
                te_cnt = 0;
            end
            if (transmitEnable) begin
                te_cnt++;
                charSent = !no_sent && te_cnt >= 10 && te_cnt <= 12;
            end else if (prev_te_g && gen_win == stuck_win) begin
                stuck_left = 15;
                charSent = 1'b1;
            end else if (stuck_left > 0) begin
                stuck_left--;
                if (stuck_left == 0) begin
                    charSent = 1'b0;
                    stuck_fall_cyc = cyc;
                end
            end else begin
                charSent = 1'b0;
            end
            prev_te_g = transmitEnable;
        end
    end

    // Per-cycle compare against the packet model.
    initial begin
        bit prev_te, prev_load;
        logic [7:0] eb;
        prev_te = 0;
        prev_load = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                te_rises = 0;
                prev_te = 0;
                prev_load = 0;
                exp_q.delete();
            end else begin
                chk("ready_is_not_busy", msgReady, !busy);
                if (transmitEnable && !prev_te) begin
                    te_rises++;
                    te_rise_cyc = cyc;
                end
                if (!transmitEnable && prev_te) te_fall_cyc = cyc;
                if (load) begin
                    chk("load_width", prev_load, 0);
                    chk("load_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        eb = exp_q.pop_front();
                        chk("load_byte", parDataOut, eb);
                    end
                    if (te_rises > 0 && !stuck_pkt)
                        chk("gap_to_load", cyc - te_fall_cyc, GAP + 1);
                    last_loaded = parDataOut;
                    load_log.push_back(parDataOut);
                    load_cyc_log.push_back(cyc);
                end
                if (transmitEnable) chk("data_hold", parDataOut, last_loaded);
                if (txDone) begin
                    chk("done_windows", te_rises, 4);
                    chk("done_all_sent", exp_q.size(), 0);
                    chk("done_gap", cyc - te_fall_cyc, GAP);
                    te_rises = 0;
                end
                if (txError) begin
                    te_rises = 0;
                    exp_q.delete();
                end
                prev_te = transmitEnable;
                prev_load = load;
            end
        end
    end

    // Offer one message in an idle cycle; checks accept/reject latency.
    task automatic send_msg(input logic [1:0] t, input logic [3:0] r, input logic [3:0] c,
                            output bit rej);
        logic [31:0] w;
        int nl;
        rej = (r > 4'd9) || (c > 4'd9);
        nl = load_log.size();
        msgValid = 1'b1;
        msgType = t;
        row = r;
        col = c;
        @(posedge clk);
        #1;
        msgValid = 1'b0;
        if (rej) begin
            chk("rej_error", txError, 1);
            chk("rej_ready", msgReady, 1);
            chk("rej_busy", busy, 0);
            @(posedge clk);
            #1;
            chk("rej_pulse", txError, 0);
            repeat (4) @(posedge clk);
            #1;
            chk("rej_noload", load_log.size() - nl, 0);
        end else begin
            w = pkt_word(t, r, c);
            for (int i = 3; i >= 0; i--) exp_q.push_back(w[i*8 +: 8]);
            chk("acc_busy", busy, 1);
            chk("acc_ready", msgReady, 0);
            chk("setup_data", parDataOut, 8'hA5);
            chk("setup_noload", load, 0);
            @(posedge clk);
            #1;
            chk("load_latency", load, 1);
            chk("te_before", transmitEnable, 0);
            @(posedge clk);
            #1;
            chk("te_latency", transmitEnable, 1);
            chk("load_after", load, 0);
        end
    endtask

    task automatic wait_end(output bit done, output bit err);
        done = 0;
        err = 0;
        for (int i = 0; i < 3000 && !done && !err; i++) begin
            @(posedge clk);
            #1;
            done = txDone;
            err = txError;
        end
        chk("end_seen", done | err, 1);
    endtask

    initial begin
        bit d, e, rej, got;
        int base, ndone;
        logic [7:0] lit[4];
        logic [1:0] t;
        logic [3:0] r, c;

        reset = 1'b1;
        msgValid = 1'b0;
        msgType = '0;
        row = '0;
        col = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data", parDataOut, 8'h00);
        chk("rst_load", load, 0);
        chk("rst_te", transmitEnable, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", txDone, 0);
        chk("rst_err", txError, 0);
        chk("rst_ready", msgReady, 1);
        reset = 1'b0;

        chk("model_pin_a", pkt_word(2'd1, 4'd3, 4'd7), 32'hA5370193);
        chk("model_pin_b", pkt_word(2'd3, 4'd9, 4'd9), 32'hA599033F);

        // normal packet
        base = load_log.size();
        send_msg(2'd1, 4'd3, 4'd7, rej);
        wait_end(d, e);
        chk("t1_done", d, 1);
        chk("t1_ready", msgReady, 1);
        chk("t1_nloads", load_log.size() - base, 4);
        lit[0] = 8'hA5; lit[1] = 8'h37; lit[2] = 8'h01; lit[3] = 8'h93;
        if (load_log.size() >= base + 4)
            for (int i = 0; i < 4; i++) chk("t1_byte", load_log[base+i], lit[i]);
        @(posedge clk);
        #1;
        chk("t1_done_pulse", txDone, 0);

        // coordinate reject
        send_msg(2'd0, 4'd10, 4'd2, rej);
        chk("t2_rej", rej, 1);

        // timeout with charSent never rising
        no_sent = 1;
        send_msg(2'd2, 4'd4, 4'd4, rej);
        wait_end(d, e);
        chk("t3_err", e, 1);
        chk("t3_when", cyc - te_rise_cyc, TMO);
        chk("t3_te", transmitEnable, 0);
        chk("t3_busy", busy, 0);
        chk("t3_ready", msgReady, 1);
        no_sent = 0;
        repeat (2) @(posedge clk);
        #1;

        // charSent stuck high past gap expiry after b1
        stuck_win = 2;
        stuck_pkt = 1;
        base = load_log.size();
        send_msg(2'd3, 4'd0, 4'd9, rej);
        wait_end(d, e);
        chk("t4_done", d, 1);
        chk("t4_nloads", load_log.size() - base, 4);
        if (load_log.size() >= base + 4)
            chk("t4_b2_after_fall", load_cyc_log[base+2] - stuck_fall_cyc, 2);
        stuck_win = 0;
        stuck_pkt = 0;

        // reset during byte 2 SEND
        send_msg(2'd2, 4'd5, 4'd6, rej);
        got = 0;
        for (int i = 0; i < 500 && !got; i++) begin
            @(posedge clk);
            #1;
            if (transmitEnable && gen_win == 3) got = 1;
        end
        chk("t5_reach_b2", got, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("t5_te", transmitEnable, 0);
        chk("t5_load", load, 0);
        chk("t5_data", parDataOut, 8'h00);
        chk("t5_ready", msgReady, 1);
        chk("t5_busy", busy, 0);
        reset = 1'b0;
        ndone = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (txDone) ndone++;
        end
        chk("t5_no_done", ndone, 0);
        base = load_log.size();
        send_msg(2'd0, 4'd2, 4'd8, rej);
        wait_end(d, e);
        chk("t5_new_done", d, 1);
        if (load_log.size() > base) chk("t5_new_b0", load_log[base], 8'hA5);

        // msgValid while busy is ignored
        base = load_log.size();
        send_msg(2'd1, 4'd6, 4'd2, rej);
        repeat (5) @(posedge clk);
        #1;
        chk("t6_not_ready", msgReady, 0);
        msgValid = 1'b1;
        msgType = 2'd3;
        row = 4'd1;
        col = 4'd1;
        @(posedge clk);
        #1;
        msgValid = 1'b0;
        wait_end(d, e);
        chk("t6_done", d, 1);
        lit[0] = 8'hA5; lit[1] = 8'h62; lit[2] = 8'h01; lit[3] = 8'hC6;
        chk("t6_nloads", load_log.size() - base, 4);
        if (load_log.size() >= base + 4)
            for (int i = 0; i < 4; i++) chk("t6_byte", load_log[base+i], lit[i]);

        // random messages, legal and illegal coordinates
        for (int k = 0; k < 20; k++) begin
            t = 2'($urandom_range(0, 3));
            r = 4'($urandom_range(0, 11));
            c = 4'($urandom_range(0, 11));
            send_msg(t, r, c, rej);
            if (!rej) begin
                wait_end(d, e);
                chk("rnd_done", d, 1);
            end
        end

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
